// File: rtl/seq_divider_32.sv
// Restoring divider, one quotient bit per cycle MSB first; `SEQ_DIVIDER_SIGNED_EN selects two's-complement operands.
// Latency: done pulses WIDTH+1 cycles after the accepting edge, or 1 cycle after when the divisor is zero.
// Backpressure: start is sampled only in IDLE and ignored while busy; results hold until the next done.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             div_zero;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_q;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;

  assign div_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic negq_q;
  logic negr_q;

  // A zero divisor keeps the raw dividend so it can be returned as the remainder.
  assign op_a  = (dividend[WIDTH-1] && !div_zero) ? -dividend : dividend;
  assign op_b  = divisor[WIDTH-1] ? -divisor : divisor;
  assign res_q = negq_q ? -quo_q : quo_q;
  assign res_r = negr_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (accept) begin
      negq_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      negr_q <= dividend[WIDTH-1];
    end
  end
`else
  assign op_a  = dividend;
  assign op_b  = divisor;
  assign res_q = quo_q;
  assign res_r = rem_q;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Trial subtraction at WIDTH+1 bits; the top bit of diff is the borrow.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign q_bit   = ~diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      dvd_q <= op_a;
      dvs_q <= op_b;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      dz_q  <= div_zero;
    end else if (state == CALC) begin
      rem_q <= q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], q_bit};
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        quotient    <= dz_q ? '1 : res_q;
        remainder   <= dz_q ? dvd_q : res_r;
        div_by_zero <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
// Scoreboard bench for seq_divider_32: expectations queued at start, checked on each done pulse.
// Signed-mode vectors are included when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider_32;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  seq_divider_32 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.cyc = 0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.dz = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = a;
        e.r = '0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  // Called at a falling edge; start is seen by the next rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e     = model(a, b);
      e.cyc = cyc + ((b == '0) ? 2 : W + 2);
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency", cyc, e.cyc);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(32'd100, 32'd7, 1'b1);
    chk("busy_calc", {31'd0, busy}, 32'd1);
    wait_done();

    @(negedge clk);
    launch(32'd5, 32'd0, 1'b1);
    wait_done();

    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_done();
    launch(32'd3, 32'd10, 1'b1);
    repeat (4) @(negedge clk);
    chk("hold_quotient", quotient, 32'hFFFF_FFFF);
    wait_done();

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    launch(32'd1000, 32'd10, 1'b1);
    repeat (4) @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done();

    // Reset in the middle of CALC abandons the operation.
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done_busy", {31'd0, busy}, 32'd0);
    launch(32'd50, 32'd5, 1'b1);
    wait_done();

`ifdef SEQ_DIVIDER_SIGNED_EN
    @(negedge clk);
    launch(-32'sd7, 32'd2, 1'b1);
    wait_done();
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    launch(32'd7, -32'sd2, 1'b1);
    wait_done();
`endif

    // Random operands, chained back-to-back.
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = a + W'($urandom_range(1, 5));
      endcase
      launch(a, b, 1'b1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_divider_32.md
SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH: numerator; captured on the accepted start.
REQ-006 SHALL have port divisor, input, WIDTH: denominator; captured on the accepted start.
REQ-007 SHALL have port busy, output, 1: high while in CALC or DONE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse; results valid.
REQ-009 SHALL have port quotient, output, WIDTH: result quotient.
REQ-010 SHALL have port remainder, output, WIDTH: result remainder.
REQ-011 SHALL have port div_by_zero, output, 1: last completed operation had divisor == 0.

Function
REQ-012 SHALL implement restoring division, producing one quotient bit per cycle, MSB first.
REQ-013 SHALL use a 3-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL accept start only in IDLE; an accepted start captures the operands and moves to CALC, or to DONE if divisor == 0.
REQ-015 SHALL, in CALC, per cycle: shift the partial remainder left by 1 with the next dividend bit in; trial-subtract the divisor at WIDTH+1 bits; on non-negative difference keep it and set the quotient bit to 1, else restore and set it to 0.
REQ-016 SHALL stay in CALC for exactly WIDTH cycles, counted by an internal iteration counter, then go to DONE.
REQ-017 SHALL, in DONE, assert done for one cycle, update quotient/remainder/div_by_zero in the same cycle, then return to IDLE.
REQ-018 SHALL assert done exactly WIDTH+1 cycles after the accepting edge for a nonzero divisor, and 1 cycle after for a zero divisor.
REQ-019 SHALL ignore start while busy; operands and the computation SHALL be unaffected.
REQ-020 SHALL accept a start asserted in the cycle after done (IDLE) with no bubble requirement beyond that.
REQ-021 SHALL, on divisor == 0, output quotient = all ones, remainder = dividend, and div_by_zero = 1.
REQ-022 SHALL hold quotient, remainder and div_by_zero stable from done until the next done.
REQ-023 SHALL, when dividend < divisor, output quotient 0 and remainder = dividend.

Reset
REQ-024 SHALL, on rst_n low, immediately force: FSM = IDLE, counter = 0, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0.
REQ-025 SHALL abandon any operation in progress on reset mid-CALC, with no done pulse afterwards.
REQ-026 SHALL not accept start until the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro SEQ_DIVIDER_SIGNED_EN defined, treat operands as two's complement:
- divide magnitudes, then negate the quotient if the operand signs differ;
- remainder takes the sign of the dividend (truncation toward zero);
- most-negative / -1 yields quotient = most-negative, remainder = 0;
- latency per REQ-018 is unchanged.
REQ-028 SHALL, without SEQ_DIVIDER_SIGNED_EN, treat all operands as unsigned and contain no sign-correction logic.
REQ-029 SHALL keep divide-by-zero behaviour per REQ-021 in both configurations.

Verification
REQ-030 SHALL cover: 100 / 7, unsigned -> done 33 cycles after start, quotient 14, remainder 2, div_by_zero 0.
REQ-031 SHALL cover: 5 / 0 -> done 1 cycle after start, quotient 0xFFFFFFFF, remainder 5, div_by_zero 1.
REQ-032 SHALL cover: 0xFFFFFFFF / 1, then a back-to-back start the cycle after done with 3 / 10 -> first result quotient 0xFFFFFFFF, remainder 0; second result quotient 0, remainder 3.
REQ-033 SHALL cover: start pulsed with 9 / 3 at cycle 5 of a 1000 / 10 operation -> the start is ignored; result quotient 100, remainder 0, at the original latency.
REQ-034 SHALL cover: rst_n low at cycle 10 of a CALC -> all outputs 0 immediately, no done pulse; a new 50 / 5 after reset gives quotient 10, remainder 0.
REQ-035 SHALL cover, with SEQ_DIVIDER_SIGNED_EN: -7 / 2 -> quotient -3, remainder -1; 0x80000000 / -1 -> quotient 0x80000000, remainder 0.
